// File: rtl/delay_line_cfg.sv
// delay_line_cfg -- multi-channel fixed-latency delay line with a runtime
// programmable delay and per-sample valid tracking.
//
// A MAX_DELAY deep shift register carries {data, valid}. The output taps
// stage[act_delay-1], so a sample accepted at edge t is visible after edge
// t+act_delay-1. A new delay is applied safely: the line first drains every
// in-flight sample with the old delay (inputs refused), then one APPLY cycle
// clears the storage and switches the tap.
//
// Ports:
//   aclk       clock, rising edge
//   aresetn    asynchronous active-low reset
//   en         advance enable (stall when low)
//   flush      synchronous clear of stages, error flag and pending request
//   cfg_delay  requested delay (1..MAX_DELAY)
//   cfg_load   single-cycle strobe requesting cfg_delay
//   din        input data, channel c at [c*BITWIDTH +: BITWIDTH]
//   valid      din valid
//   din_ready  high while new samples are accepted
//   dout       delayed data, zero when dvalid is low
//   dvalid     delayed valid
//   busy       any valid sample in stages 0..act_delay-1
//   act_delay  delay currently in force
//   cfg_err    sticky flag for an out-of-range request
module delay_line_cfg #(
  parameter int MAX_DELAY     = 16,
  parameter int BITWIDTH      = 32,
  parameter int CHANNELS      = 1,
  parameter int DEFAULT_DELAY = 1,
  parameter int HOLD_ON_STALL = 1,
  parameter int DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         en,
  input  logic                         flush,
  input  logic [DW-1:0]                cfg_delay,
  input  logic                         cfg_load,
  input  logic [CHANNELS*BITWIDTH-1:0] din,
  input  logic                         valid,
  output logic                         din_ready,
  output logic [CHANNELS*BITWIDTH-1:0] dout,
  output logic                         dvalid,
  output logic                         busy,
  output logic [DW-1:0]                act_delay,
  output logic                         cfg_err
);

  localparam int W = CHANNELS * BITWIDTH;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  logic [W-1:0]         data_q [MAX_DELAY];
  logic [W-1:0]         data_d [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld_q;
  logic [MAX_DELAY-1:0] vld_d;
  state_t               state_q;
  state_t               state_d;
  logic [DW-1:0]        act_q;
  logic [DW-1:0]        act_d;
  logic [DW-1:0]        pend_q;
  logic [DW-1:0]        pend_d;
  logic                 err_q;
  logic                 err_d;

  logic                 busy_s;
  logic [W-1:0]         tap_data_s;
  logic                 tap_vld_s;
  logic                 accepted_s;
  logic                 cfg_legal_s;

  assign din_ready   = (state_q == ST_RUN);
  assign accepted_s  = valid & din_ready;
  assign cfg_legal_s = (cfg_delay != {DW{1'b0}}) && (cfg_delay <= MAX_D);

  // Occupancy of the active part of the line; stages beyond the tap are
  // already past the output and do not count.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (vld_q[i] && (i < int'(act_q))) begin
        busy_s = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
  end

  // Output tap mux selecting stage[act_delay-1] from registered stages.
  always_comb begin
    tap_data_s = {W{1'b0}};
    tap_vld_s  = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (int'(act_q) == (i + 1)) begin
        tap_data_s = data_q[i];
        tap_vld_s  = vld_q[i];
      end else begin
        tap_vld_s  = tap_vld_s;
      end
    end
  end

  assign busy      = busy_s;
  assign dvalid    = tap_vld_s;
  assign dout      = tap_vld_s ? tap_data_s : {W{1'b0}};
  assign act_delay = act_q;
  assign cfg_err   = err_q;

  // Next-state logic: storage shift/hold/clear, FSM and error flag.
  always_comb begin
    data_d  = data_q;
    vld_d   = vld_q;
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    err_d   = err_q;

    if (flush) begin
      // Flush dominates everything, including any request being drained.
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_d[i] = {W{1'b0}};
      end
      vld_d   = {MAX_DELAY{1'b0}};
      err_d   = 1'b0;
      state_d = ST_RUN;
      pend_d  = act_q;
    end else begin
      // Range errors are flagged in every state, even when the request
      // itself is ignored.
      if (cfg_load && !cfg_legal_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      if (en) begin
        case (state_q)
          ST_RUN: begin
            if (cfg_load && cfg_legal_s && (cfg_delay != act_q)) begin
              pend_d  = cfg_delay;
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end
          ST_DRAIN: begin
            if (!busy_s) begin
              state_d = ST_APPLY;
            end else begin
              state_d = ST_DRAIN;
            end
          end
          ST_APPLY: begin
            act_d   = pend_q;
            state_d = ST_RUN;
          end
          default: begin
            state_d = ST_RUN;
          end
        endcase

        if (state_q == ST_APPLY) begin
          // Stages beyond the old tap may still hold drained samples; clear
          // them so a longer new delay cannot re-emit them.
          for (int i = 0; i < MAX_DELAY; i++) begin
            data_d[i] = {W{1'b0}};
          end
          vld_d = {MAX_DELAY{1'b0}};
        end else begin
          data_d[0] = accepted_s ? din : {W{1'b0}};
          vld_d[0]  = accepted_s;
          for (int i = 1; i < MAX_DELAY; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
          end
        end
      end else if (HOLD_ON_STALL == 0) begin
        for (int i = 0; i < MAX_DELAY; i++) begin
          data_d[i] = {W{1'b0}};
        end
        vld_d = {MAX_DELAY{1'b0}};
      end else begin
        vld_d = vld_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_q[i] <= {W{1'b0}};
      end
      vld_q   <= {MAX_DELAY{1'b0}};
      state_q <= ST_RUN;
      act_q   <= DEF_D;
      pend_q  <= DEF_D;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        data_q[i] <= data_d[i];
      end
      vld_q   <= vld_d;
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_delay_line_cfg.sv
module tb_delay_line_cfg;

  localparam int MAXD = 16;
  localparam int BW   = 8;
  localparam int CH   = 2;
  localparam int DW   = 5;

  logic          aclk;
  logic          aresetn;
  logic          en;
  logic          flush;
  logic [DW-1:0] cfg_delay;
  logic          cfg_load;
  logic [15:0]   din;
  logic          valid;

  logic          h_ready, h_dvalid, h_busy, h_err;
  logic [15:0]   h_dout;
  logic [DW-1:0] h_act;
  logic          c_ready, c_dvalid, c_busy, c_err;
  logic [15:0]   c_dout;
  logic [DW-1:0] c_act;

  int n_tests = 0;
  int n_fail  = 0;

  delay_line_cfg #(
    .MAX_DELAY(MAXD), .BITWIDTH(BW), .CHANNELS(CH),
    .DEFAULT_DELAY(4), .HOLD_ON_STALL(1)
  ) dut_h (
    .aclk(aclk), .aresetn(aresetn), .en(en), .flush(flush),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load), .din(din), .valid(valid),
    .din_ready(h_ready), .dout(h_dout), .dvalid(h_dvalid), .busy(h_busy),
    .act_delay(h_act), .cfg_err(h_err)
  );

  delay_line_cfg #(
    .MAX_DELAY(MAXD), .BITWIDTH(BW), .CHANNELS(CH),
    .DEFAULT_DELAY(3), .HOLD_ON_STALL(0)
  ) dut_c (
    .aclk(aclk), .aresetn(aresetn), .en(en), .flush(flush),
    .cfg_delay(cfg_delay), .cfg_load(cfg_load), .din(din), .valid(valid),
    .din_ready(c_ready), .dout(c_dout), .dvalid(c_dvalid), .busy(c_busy),
    .act_delay(c_act), .cfg_err(c_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic          en;
    logic          valid;
    logic [15:0]   din;
    logic          flush;
    logic          load;
    logic [DW-1:0] cd;
    logic [15:0]   e_dout;
    logic          e_dvalid;
    logic          e_ready;
    logic          e_busy;
    logic [DW-1:0] e_act;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic e, input logic v, input logic [15:0] d,
                     input logic f, input logic ld, input logic [DW-1:0] cd,
                     input logic [15:0] ed, input logic ev, input logic er,
                     input logic eb, input logic [DW-1:0] ea, input logic ee);
    vec_t t;
    t.en = e; t.valid = v; t.din = d; t.flush = f; t.load = ld; t.cd = cd;
    t.e_dout = ed; t.e_dvalid = ev; t.e_ready = er; t.e_busy = eb;
    t.e_act = ea; t.e_err = ee;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic e, input logic v, input logic [15:0] d,
                       input logic f, input logic ld, input logic [DW-1:0] cd);
    en = e; valid = v; din = d; flush = f; cfg_load = ld; cfg_delay = cd;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst h dout",   32'(h_dout),   32'h0);
    chk("rst h dvalid", 32'(h_dvalid), 32'h0);
    chk("rst h busy",   32'(h_busy),   32'h0);
    chk("rst h ready",  32'(h_ready),  32'h1);
    chk("rst h act",    32'(h_act),    32'd4);
    chk("rst h err",    32'(h_err),    32'h0);
    chk("rst c act",    32'(c_act),    32'd3);
    @(negedge aclk);
    aresetn = 1'b1;

    // en, valid, din, flush, load, cd | dout, dvalid, ready, busy, act, err
    // Basic latency at D=4, two 8-bit channels.
    add(1'b1, 1'b1, 16'h0201, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b1, 16'h0403, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0201, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0403, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0);
    // Reconfigure 4 -> 2 with three samples in flight; 0x4444 must be dropped.
    add(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 5'd2,  16'h0000, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 5'd0,  16'h1111, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h2222, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h3333, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    add(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h5555, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    // Illegal requests 0 and 17, then an equal value, then flush clears the error.
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd17, 16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd2,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    // Flush while draining towards D=5: request dropped, back to RUN at D=2.
    add(1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b1, 16'h7777, 1'b0, 1'b1, 5'd5,  16'h6666, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
    add(1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h8888, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].en, vecs[k].valid, vecs[k].din, vecs[k].flush, vecs[k].load, vecs[k].cd);
      step();
      chk($sformatf("v%0d dout", k),   32'(h_dout),   32'(vecs[k].e_dout));
      chk($sformatf("v%0d dvalid", k), 32'(h_dvalid), 32'(vecs[k].e_dvalid));
      chk($sformatf("v%0d ready", k),  32'(h_ready),  32'(vecs[k].e_ready));
      chk($sformatf("v%0d busy", k),   32'(h_busy),   32'(vecs[k].e_busy));
      chk($sformatf("v%0d act", k),    32'(h_act),    32'(vecs[k].e_act));
      chk($sformatf("v%0d err", k),    32'(h_err),    32'(vecs[k].e_err));
    end

    // Stall behaviour at D=3: hold instance keeps A, clear instance loses it.
    aresetn = 1'b0;
    #1;
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd3);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    step();
    step();
    chk("stall h act", 32'(h_act), 32'd3);
    chk("stall c act", 32'(c_act), 32'd3);
    chk("stall h ready", 32'(h_ready), 32'h1);
    drive(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    step();
    chk("stall h pre busy", 32'(h_busy), 32'h1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("stall%0d h dvalid", s), 32'(h_dvalid), 32'h0);
      chk($sformatf("stall%0d h dout", s),   32'(h_dout),   32'h0);
      chk($sformatf("stall%0d h busy", s),   32'(h_busy),   32'h1);
      chk($sformatf("stall%0d c busy", s),   32'(c_busy),   32'h0);
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    step();
    chk("stall h out dout",   32'(h_dout),   32'h0000A5A5);
    chk("stall h out dvalid", 32'(h_dvalid), 32'h1);
    chk("stall c out dvalid", 32'(c_dvalid), 32'h0);
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("stall post%0d h dvalid", s), 32'(h_dvalid), 32'h0);
      chk($sformatf("stall post%0d c dvalid", s), 32'(c_dvalid), 32'h0);
    end

    // Asynchronous reset mid-stream while a sample is on the output.
    drive(1'b1, 1'b1, 16'h0B0B, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b1, 16'h0C0C, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0);
    step();
    chk("mid h dout",   32'(h_dout),   32'h00000B0B);
    chk("mid h dvalid", 32'(h_dvalid), 32'h1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst h dout",   32'(h_dout),   32'h0);
    chk("arst h dvalid", 32'(h_dvalid), 32'h0);
    chk("arst h busy",   32'(h_busy),   32'h0);
    chk("arst h act",    32'(h_act),    32'd4);
    chk("arst h ready",  32'(h_ready),  32'h1);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("post rst%0d h dvalid", s), 32'(h_dvalid), 32'h0);
      chk($sformatf("post rst%0d h busy", s),   32'(h_busy),   32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
